// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the memory-unit FSM state encoding.
package cpu_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
module mem_array #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned AW     = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_c_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_unit.sv
// Unified instruction/data memory with a fixed wait-state sequence, ready pulse
// on commit, and a side preload port usable while no access is in flight.
module mem_unit #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  import cpu_pkg::*;

  mem_state_t          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                op_wr_q, op_wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [MEM_AW-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic                cur_wr;
  logic                commit;
  logic                arr_we;
  logic [MEM_AW-1:0]   arr_waddr;
  logic [DATA_W-1:0]   arr_wdata;
  logic [DATA_W-1:0]   arr_rdata;

  // Upper address bits alias onto the implemented depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_W-1:MEM_AW], ld_addr[ADDR_W-1:MEM_AW]};

  // Operation being committed: live inputs when committing straight from IDLE, else latched.
  assign cur_addr  = (state_q == MEM_IDLE) ? addr[MEM_AW-1:0] : addr_q;
  assign cur_wdata = (state_q == MEM_IDLE) ? wdata : wdata_q;
  assign cur_wr    = (state_q == MEM_IDLE) ? wr_req : op_wr_q;

  mem_array #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_array (
    .clk       (clk),
    .we_i      (arr_we),
    .waddr_i   (arr_waddr),
    .wdata_i   (arr_wdata),
    .raddr_i   (cur_addr),
    .rdata_c_o (arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_wr_d   = op_wr_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    commit    = 1'b0;
    arr_we    = 1'b0;
    arr_waddr = cur_addr;
    arr_wdata = cur_wdata;

    unique case (state_q)
      MEM_IDLE: begin
        if (ld_en) begin
          arr_we    = 1'b1;
          arr_waddr = ld_addr[MEM_AW-1:0];
          arr_wdata = ld_data;
        end else if (rd_req ^ wr_req) begin
          addr_d  = addr[MEM_AW-1:0];
          wdata_d = wdata;
          op_wr_d = wr_req;
          count_d = CNT_W'(WAIT);
          if (WAIT == 0) begin
            state_d = MEM_DONE;
            commit  = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else if (rd_req && wr_req) begin
          err_d = 1'b1;
        end
      end
      MEM_WAIT: begin
        count_d = count_q - CNT_W'(1);
        if (count_q <= CNT_W'(1)) begin
          state_d = MEM_DONE;
          commit  = 1'b1;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase

    // Commit on entry to DONE so read data is valid alongside ready.
    if (commit) begin
      if (cur_wr) begin
        arr_we = 1'b1;
      end else begin
        rdata_d = arr_rdata;
      end
    end

    ready_d = (state_d == MEM_DONE);
    busy_d  = (state_d != MEM_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MEM_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
